// File: rtl/pattern_store_pkg.sv
// pattern_store_pkg: shared constants and types for the pattern store.
//   PS_*         default parameter values for pattern_store and its interface
//   ps_state_t   read FSM state encoding
//   PS_CNT_W     width of the wait-state counter (WAIT_STATES is 0..15)
package pattern_store_pkg;

  localparam int PS_WORD_SIZE    = 8;
  localparam int PS_ADDRESS_SIZE = 4;
  localparam int PS_MEMORY_QTY   = 16;
  localparam int PS_WAIT_STATES  = 2;
  localparam int PS_CNT_W        = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } ps_state_t;

endpackage

// File: rtl/pattern_store_if.sv
// pattern_store_if: read/write bus between a sequencer (master) and the
// pattern store (slave).
//   r_en/r_addr        read request, held until r_rdy
//   r_data/r_rdy       read response
//   w_en/w_addr/w_data single-cycle write strobe
//   busy               read FSM not idle
interface pattern_store_if
  import pattern_store_pkg::*;
#(
  parameter int WORD_SIZE    = PS_WORD_SIZE,
  parameter int ADDRESS_SIZE = PS_ADDRESS_SIZE
);
  logic                    r_en;
  logic [ADDRESS_SIZE-1:0] r_addr;
  logic [WORD_SIZE-1:0]    r_data;
  logic                    r_rdy;
  logic                    w_en;
  logic [ADDRESS_SIZE-1:0] w_addr;
  logic [WORD_SIZE-1:0]    w_data;
  logic                    busy;

  modport master (output r_en, r_addr, w_en, w_addr, w_data,
                  input  r_data, r_rdy, busy);
  modport slave  (input  r_en, r_addr, w_en, w_addr, w_data,
                  output r_data, r_rdy, busy);
endinterface

// File: rtl/pattern_store_ram.sv
// pattern_store_ram: MEMORY_QTY x WORD_SIZE storage, synchronous write,
// combinational read. Addresses >= MEMORY_QTY read as 0 and ignore writes.
//   clock            write clock
//   reset            only present with PATTERN_STORE_INIT_EN: loads
//                    mem[i] = 1 << (i mod WORD_SIZE)
//   i_we/i_waddr/i_wdata  write port
//   i_raddr/o_rdata       read port
// Macro: PATTERN_STORE_INIT_EN (undefined: memory is not reset).
module pattern_store_ram #(
  parameter int WORD_SIZE    = 8,
  parameter int ADDRESS_SIZE = 4,
  parameter int MEMORY_QTY   = 16
) (
  input  logic                    clock,
`ifdef PATTERN_STORE_INIT_EN
  input  logic                    reset,
`endif
  input  logic                    i_we,
  input  logic [ADDRESS_SIZE-1:0] i_waddr,
  input  logic [WORD_SIZE-1:0]    i_wdata,
  input  logic [ADDRESS_SIZE-1:0] i_raddr,
  output logic [WORD_SIZE-1:0]    o_rdata
);

  logic [WORD_SIZE-1:0] r_mem [0:MEMORY_QTY-1];
  logic                 w_wr_ok;
  logic                 w_rd_ok;

  assign w_wr_ok = i_we && (int'(i_waddr) < MEMORY_QTY);
  assign w_rd_ok = int'(i_raddr) < MEMORY_QTY;
  assign o_rdata = w_rd_ok ? r_mem[i_raddr] : '0;

`ifdef PATTERN_STORE_INIT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MEMORY_QTY; i++)
        r_mem[i] <= WORD_SIZE'(1) << (i % WORD_SIZE);
    end else if (w_wr_ok) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end
`else
  always_ff @(posedge clock) begin
    if (w_wr_ok) r_mem[i_waddr] <= i_wdata;
  end
`endif

endmodule

// File: rtl/pattern_store.sv
// pattern_store: pattern word memory with a wait-stated read handshake.
//   clock  rising-edge clock
//   reset  asynchronous, active-high
//   bus    pattern_store_if.slave (r_en/r_addr/r_data/r_rdy, w_en/w_addr/
//          w_data, busy)
// A read sampled in IDLE completes WAIT_STATES+1 edges later counting the
// sampling edge; r_rdy/r_data then hold until r_en falls. Writes go straight
// to the RAM regardless of FSM state.
// Macro: PATTERN_STORE_INIT_EN (reset preloads the memory).
module pattern_store
  import pattern_store_pkg::*;
#(
  parameter int WORD_SIZE    = PS_WORD_SIZE,
  parameter int ADDRESS_SIZE = PS_ADDRESS_SIZE,
  parameter int MEMORY_QTY   = PS_MEMORY_QTY,
  parameter int WAIT_STATES  = PS_WAIT_STATES
) (
  input  logic             clock,
  input  logic             reset,
  pattern_store_if.slave   bus
);

  ps_state_t               r_state, w_state_nxt;
  logic [PS_CNT_W-1:0]     r_cnt;
  logic [ADDRESS_SIZE-1:0] r_addr_cap, w_rd_addr;
  logic [WORD_SIZE-1:0]    r_rdata, w_rd_word;
  logic                    w_load;

  pattern_store_ram #(
    .WORD_SIZE    (WORD_SIZE),
    .ADDRESS_SIZE (ADDRESS_SIZE),
    .MEMORY_QTY   (MEMORY_QTY)
  ) u_ram (
    .clock   (clock),
`ifdef PATTERN_STORE_INIT_EN
    .reset   (reset),
`endif
    .i_we    (bus.w_en),
    .i_waddr (bus.w_addr),
    .i_wdata (bus.w_data),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_word)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // The counter is decremented on every WAIT edge; the edge that takes it
  // from 1 to 0 is the READY-entry edge, which gives WAIT_STATES+1 edges
  // counting the IDLE sampling edge. The <= also covers a stray zero count.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (bus.r_en) w_state_nxt = (WAIT_STATES == 0) ? ST_READY : ST_WAIT;
      ST_WAIT:  if (!bus.r_en)                  w_state_nxt = ST_IDLE;
                else if (r_cnt <= PS_CNT_W'(1)) w_state_nxt = ST_READY;
      ST_READY: if (!bus.r_en) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // In IDLE the live address feeds the RAM so a zero-wait read sees the
  // address being captured on the same edge. The read is combinational, so
  // a write on the READY-entry edge is not visible to that read.
  always_comb begin
    w_rd_addr  = (r_state == ST_IDLE) ? bus.r_addr : r_addr_cap;
    w_load     = (w_state_nxt == ST_READY) && (r_state != ST_READY);
    bus.r_rdy  = (r_state == ST_READY);
    bus.busy   = (r_state != ST_IDLE);
    bus.r_data = r_rdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_addr_cap <= '0;
      r_rdata    <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: if (bus.r_en) begin
          r_cnt      <= PS_CNT_W'(WAIT_STATES);
          r_addr_cap <= bus.r_addr;
        end
        ST_WAIT: r_cnt <= bus.r_en ? r_cnt - PS_CNT_W'(1) : '0;
        default: ;
      endcase
      if (w_load) r_rdata <= w_rd_word;
    end
  end

endmodule

// File: tb/tb_pattern_store.sv
// tb_pattern_store: directed bench over three pattern_store instances:
//   0: defaults (WAIT_STATES=2, MEMORY_QTY=16)
//   1: WAIT_STATES=0
//   2: MEMORY_QTY=12
// Expected read data is queued when a read is issued and popped when r_rdy
// is seen.
module tb_pattern_store;
  localparam int AW = 4;
  localparam int DW = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [2:0]              r_en, w_en;
  logic [2:0][AW-1:0]      r_addr, w_addr;
  logic [2:0][DW-1:0]      w_data;
  wire  [2:0][DW-1:0]      r_data;
  wire  [2:0]              r_rdy, busy;

  logic [DW-1:0] sb[$];
  int n_chk  = 0;
  int n_fail = 0;

  pattern_store_if #(.WORD_SIZE(DW), .ADDRESS_SIZE(AW)) bus0 ();
  pattern_store_if #(.WORD_SIZE(DW), .ADDRESS_SIZE(AW)) bus1 ();
  pattern_store_if #(.WORD_SIZE(DW), .ADDRESS_SIZE(AW)) bus2 ();

  assign bus0.r_en = r_en[0]; assign bus0.r_addr = r_addr[0];
  assign bus0.w_en = w_en[0]; assign bus0.w_addr = w_addr[0]; assign bus0.w_data = w_data[0];
  assign r_data[0] = bus0.r_data; assign r_rdy[0] = bus0.r_rdy; assign busy[0] = bus0.busy;
  assign bus1.r_en = r_en[1]; assign bus1.r_addr = r_addr[1];
  assign bus1.w_en = w_en[1]; assign bus1.w_addr = w_addr[1]; assign bus1.w_data = w_data[1];
  assign r_data[1] = bus1.r_data; assign r_rdy[1] = bus1.r_rdy; assign busy[1] = bus1.busy;
  assign bus2.r_en = r_en[2]; assign bus2.r_addr = r_addr[2];
  assign bus2.w_en = w_en[2]; assign bus2.w_addr = w_addr[2]; assign bus2.w_data = w_data[2];
  assign r_data[2] = bus2.r_data; assign r_rdy[2] = bus2.r_rdy; assign busy[2] = bus2.busy;

  pattern_store #(.WORD_SIZE(DW), .ADDRESS_SIZE(AW), .MEMORY_QTY(16), .WAIT_STATES(2))
    dut0 (.clock(clock), .reset(reset), .bus(bus0));
  pattern_store #(.WORD_SIZE(DW), .ADDRESS_SIZE(AW), .MEMORY_QTY(16), .WAIT_STATES(0))
    dut1 (.clock(clock), .reset(reset), .bus(bus1));
  pattern_store #(.WORD_SIZE(DW), .ADDRESS_SIZE(AW), .MEMORY_QTY(12), .WAIT_STATES(2))
    dut2 (.clock(clock), .reset(reset), .bus(bus2));

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(int k, string tag);
    n_chk++;
    assert (sb.size() > 0) else begin
      n_fail++;
      $error("FAIL %s_sb: observed empty scoreboard expected one entry", tag);
    end
    if (sb.size() > 0) chk(tag, r_data[k], sb.pop_front());
  endtask

  task automatic wr(int k, logic [AW-1:0] a, logic [DW-1:0] d);
    @(negedge clock); w_en[k] = 1'b1; w_addr[k] = a; w_data[k] = d;
    @(negedge clock); w_en[k] = 1'b0;
  endtask

  // Issue a read and wait (bounded) for r_rdy; lat counts negedges after
  // the one where r_en was raised, i.e. edges including the sampling edge.
  task automatic rd(int k, string tag, logic [AW-1:0] a, logic [DW-1:0] exp, int lat);
    int n = 0;
    sb.push_back(exp);
    @(negedge clock); r_en[k] = 1'b1; r_addr[k] = a;
    do begin @(negedge clock); n++; end while (!r_rdy[k] && n < 20);
    chk({tag, "_lat"}, n, lat);
    pop_chk(k, tag);
  endtask

  task automatic drop(int k, string tag);
    r_en[k] = 1'b0;
    @(negedge clock);
    chk({tag, "_rdy0"},  r_rdy[k], 0);
    chk({tag, "_busy0"}, busy[k],  0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1);
  end

  initial begin
    r_en = '0; w_en = '0; r_addr = '0; w_addr = '0; w_data = '0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      chk("rst_rdy",  r_rdy[k],  0);
      chk("rst_busy", busy[k],   0);
      chk("rst_data", r_data[k], 0);
    end
    reset = 1'b0;

`ifndef PATTERN_STORE_INIT_EN
    wr(0, 4'd3, 8'h08);
    wr(0, 4'd7, 8'h80);
`endif
    rd(0, "rd3", 4'd3, 8'h08, 3);
    drop(0, "rd3");

    // hold in READY for 4 cycles with a write to the held address
    wr(0, 4'd5, 8'hA5);
    rd(0, "rd5", 4'd5, 8'hA5, 3);
    w_en[0] = 1'b1; w_addr[0] = 4'd5; w_data[0] = 8'h11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock); w_en[0] = 1'b0;
      chk("hold_data", r_data[0], 8'hA5);
      chk("hold_rdy",  r_rdy[0],  1);
      chk("hold_busy", busy[0],   1);
    end
    drop(0, "rd5");
    rd(0, "rd5b", 4'd5, 8'h11, 3);
    drop(0, "rd5b");

    // abort one cycle into WAIT
    @(negedge clock); r_en[0] = 1'b1; r_addr[0] = 4'd3;
    @(negedge clock);
    chk("abort_busy1", busy[0], 1);
    r_en[0] = 1'b0;
    @(negedge clock);
    chk("abort_busy0", busy[0], 0);
    for (int i = 0; i < 3; i++) begin
      chk("abort_rdy0", r_rdy[0], 0);
      chk("abort_data", r_data[0], 8'h11);
      @(negedge clock);
    end

    // write on the READY-entry edge returns the old word
    sb.push_back(8'h80);
    @(negedge clock); r_en[0] = 1'b1; r_addr[0] = 4'd7;
    @(negedge clock);
    @(negedge clock); w_en[0] = 1'b1; w_addr[0] = 4'd7; w_data[0] = 8'h3C;
    @(negedge clock); w_en[0] = 1'b0;
    chk("same_rdy", r_rdy[0], 1);
    pop_chk(0, "same_data");
    drop(0, "same");
    rd(0, "reread7", 4'd7, 8'h3C, 3);
    drop(0, "reread7");

    // write during WAIT is returned
    sb.push_back(8'h5A);
    @(negedge clock); r_en[0] = 1'b1; r_addr[0] = 4'd9;
    @(negedge clock); w_en[0] = 1'b1; w_addr[0] = 4'd9; w_data[0] = 8'h5A;
    @(negedge clock); w_en[0] = 1'b0;
    chk("wwait_rdy_early", r_rdy[0], 0);
    @(negedge clock);
    chk("wwait_rdy", r_rdy[0], 1);
    pop_chk(0, "wwait_data");
    drop(0, "wwait");

    // zero wait states
    wr(1, 4'd2, 8'h42);
    rd(1, "ws0", 4'd2, 8'h42, 1);
    drop(1, "ws0");

    // out-of-range addresses with MEMORY_QTY=12
    wr(2, 4'd2, 8'h22);
    rd(2, "oob14", 4'd14, 8'h00, 3);
    drop(2, "oob14");
    wr(2, 4'd14, 8'hFF);
    rd(2, "oob14b", 4'd14, 8'h00, 3);
    drop(2, "oob14b");
    rd(2, "alias2", 4'd2, 8'h22, 3);
    drop(2, "alias2");
    wr(2, 4'd11, 8'h77);
    rd(2, "edge11", 4'd11, 8'h77, 3);
    drop(2, "edge11");

    // asynchronous reset during WAIT
    @(negedge clock); r_en[0] = 1'b1; r_addr[0] = 4'd3;
    @(negedge clock);
    chk("rstw_busy1", busy[0], 1);
    #2 reset = 1'b1;
    #1;
    chk("rstw_rdy",  r_rdy[0],  0);
    chk("rstw_busy", busy[0],   0);
    chk("rstw_data", r_data[0], 0);
    r_en[0] = 1'b0;
    @(negedge clock); reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("rstw_norp", r_rdy[0], 0);
      chk("rstw_idle", busy[0],  0);
    end
    rd(0, "post_rst", 4'd3, 8'h08, 3);
    drop(0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
